// File: rtl/digit_pair_sequencer_if.sv
// Handshake bundle between the operand source, the digit pair sequencer and the digit multiplier.
// The slave modport is the sequencer side; the master modport is the producer/consumer side.
interface digit_pair_sequencer_if #(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4
);
    localparam int POS_W = $clog2(2*DIGITS-1);

    logic                      clear;
    logic                      mode;
    logic                      skip_zero;
    logic                      in_valid;
    logic                      in_ready;
    logic [DIGITS*DIGIT_W-1:0] in_a;
    logic [DIGITS*DIGIT_W-1:0] in_b;
    logic                      out_valid;
    logic                      out_ready;
    logic [DIGIT_W-1:0]        out_digit_a;
    logic [DIGIT_W-1:0]        out_digit_b;
    logic [POS_W-1:0]          out_pos;
    logic                      out_first;
    logic                      done;
    logic                      busy;

    modport master (
        output clear, mode, skip_zero, in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_digit_a, out_digit_b, out_pos, out_first, done, busy
    );

    modport slave (
        input  clear, mode, skip_zero, in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_digit_a, out_digit_b, out_pos, out_first, done, busy
    );
endinterface

// File: rtl/digit_pair_sequencer.sv
// Stages two multi-digit operands and streams (a[i], b[j], i+j) digit pairs to the digit
// multiplier, in cross-product or diagonal order, optionally skipping pairs with a zero digit.
module digit_pair_sequencer #(
    parameter  int DIGITS  = 4,
    parameter  int DIGIT_W = 4,
    localparam int IDX_W   = $clog2(DIGITS),
    localparam int POS_W   = $clog2(2*DIGITS-1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    digit_pair_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] I_MAX = IDX_W'(DIGITS-1);

    state_t                    state_q, state_d;
    logic [DIGITS*DIGIT_W-1:0] a_q, a_d;
    logic [DIGITS*DIGIT_W-1:0] b_q, b_d;
    logic                      mode_q, mode_d;
    logic                      skip_q, skip_d;
    logic [IDX_W-1:0]          i_q, i_d;
    logic [IDX_W-1:0]          j_q, j_d;
    logic                      first_q, first_d;

    logic [DIGIT_W-1:0] a_dig [DIGITS];
    logic [DIGIT_W-1:0] b_dig [DIGITS];

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_unpack
        assign a_dig[gi] = a_q[gi*DIGIT_W +: DIGIT_W];
        assign b_dig[gi] = b_q[gi*DIGIT_W +: DIGIT_W];
    end

    logic [DIGIT_W-1:0] cand_a;
    logic [DIGIT_W-1:0] cand_b;
    logic               running;
    logic               skipped;
    logic               advance;
    logic               last_cand;

    assign cand_a    = a_dig[i_q];
    assign cand_b    = b_dig[j_q];
    assign running   = (state_q == S_RUN);
    assign skipped   = skip_q && ((cand_a == '0) || (cand_b == '0));
    // A skipped candidate moves on by itself; an offered one waits for the consumer.
    assign advance   = running && (skipped || bus.out_ready);
    assign last_cand = mode_q ? (i_q == I_MAX) : ((i_q == I_MAX) && (j_q == I_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= 1'b0;
            skip_q  <= 1'b0;
            i_q     <= '0;
            j_q     <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            skip_q  <= skip_d;
            i_q     <= i_d;
            j_q     <= j_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        skip_d  = skip_q;
        i_d     = i_q;
        j_d     = j_q;
        first_d = first_q;

        bus.in_ready    = 1'b0;
        bus.out_valid   = 1'b0;
        bus.out_digit_a = '0;
        bus.out_digit_b = '0;
        bus.out_pos     = '0;
        bus.out_first   = 1'b0;
        bus.done        = 1'b0;
        bus.busy        = 1'b0;

        case (state_q)
            S_IDLE: begin
                bus.in_ready = !bus.clear;
                if (bus.in_valid && !bus.clear) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    mode_d  = bus.mode;
                    skip_d  = bus.skip_zero;
                    i_d     = '0;
                    j_d     = '0;
                    first_d = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                bus.busy        = 1'b1;
                bus.out_valid   = !skipped;
                bus.out_digit_a = cand_a;
                bus.out_digit_b = cand_b;
                bus.out_pos     = POS_W'(i_q) + POS_W'(j_q);
                bus.out_first   = first_q && !skipped;
                if (advance) begin
                    if (!skipped) begin
                        first_d = 1'b0;
                    end
                    if (last_cand) begin
                        state_d = S_DONE;
                    end else if (mode_q) begin
                        i_d = i_q + IDX_W'(1);
                        j_d = j_q + IDX_W'(1);
                    end else if (i_q == I_MAX) begin
                        i_d = '0;
                        j_d = j_q + IDX_W'(1);
                    end else begin
                        i_d = i_q + IDX_W'(1);
                    end
                end
            end
            S_DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything, including a pending capture or final advance.
        if (bus.clear) begin
            state_d = S_IDLE;
            first_d = 1'b0;
        end
    end
endmodule

// File: tb/tb_digit_pair_sequencer.sv
// Directed bench for digit_pair_sequencer: ordering, skipping, backpressure, clear and async reset.
module tb_digit_pair_sequencer;
    localparam int DIGITS  = 4;
    localparam int DIGIT_W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    digit_pair_sequencer_if #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W)) bus ();

    digit_pair_sequencer #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int a;
        int b;
        int pos;
        int first;
        int cyc;
    } beat_t;

    beat_t beats[$];
    beat_t exp_q[$];
    int    done_cyc[$];
    int    cyc     = 0;
    int    n_tests = 0;
    int    n_fail  = 0;

    // Log every accepted beat and every done pulse, one line per transaction.
    always @(negedge clk) begin
        beat_t bt;
        cyc = cyc + 1;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            bt.a     = int'(bus.out_digit_a);
            bt.b     = int'(bus.out_digit_b);
            bt.pos   = int'(bus.out_pos);
            bt.first = int'(bus.out_first);
            bt.cyc   = cyc;
            beats.push_back(bt);
            $display("[TB] beat a=%0d b=%0d pos=%0d first=%0d cyc=%0d", bt.a, bt.b, bt.pos, bt.first, cyc);
        end
        if (rst_n && bus.done) begin
            done_cyc.push_back(cyc);
            $display("[TB] done cyc=%0d", cyc);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic beat_t get_beat(input int k);
        beat_t z;
        z = '{a: -1, b: -1, pos: -1, first: -1, cyc: -1};
        if (k < beats.size()) z = beats[k];
        return z;
    endfunction

    // Reference pair list: j outer, i inner; diagonal keeps i==j only.
    task automatic build_exp(input logic [15:0] a, input logic [15:0] b, input logic md, input logic sk);
        int first;
        beat_t e;
        exp_q.delete();
        first = 1;
        for (int j = 0; j < DIGITS; j++) begin
            for (int i = 0; i < DIGITS; i++) begin
                int da;
                int db;
                da = int'(a[i*4 +: 4]);
                db = int'(b[j*4 +: 4]);
                if (!(md && i != j) && !(sk && (da == 0 || db == 0))) begin
                    e = '{a: da, b: db, pos: i + j, first: first, cyc: 0};
                    exp_q.push_back(e);
                    first = 0;
                end
            end
        end
    endtask

    task automatic compare_beats(input string tag);
        beat_t g;
        chk($sformatf("%s_count", tag), beats.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            g = get_beat(k);
            chk($sformatf("%s_b%0d_a", tag, k), g.a, exp_q[k].a);
            chk($sformatf("%s_b%0d_b", tag, k), g.b, exp_q[k].b);
            chk($sformatf("%s_b%0d_pos", tag, k), g.pos, exp_q[k].pos);
            chk($sformatf("%s_b%0d_first", tag, k), g.first, exp_q[k].first);
        end
    endtask

    // Returns cap such that cycle k of the operation is logged with cyc == cap + k.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic md,
                            input logic sk, output int cap);
        beats.delete();
        done_cyc.delete();
        chk("in_ready_before_capture", int'(bus.in_ready), 1);
        bus.in_a      = a;
        bus.in_b      = b;
        bus.mode      = md;
        bus.skip_zero = sk;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        cap = cyc;
        // Scramble the inputs: the latched copies must carry the operation.
        bus.in_valid  = 1'b0;
        bus.in_a      = ~a;
        bus.in_b      = ~b;
        bus.mode      = ~md;
        bus.skip_zero = ~sk;
        chk("busy_after_capture", int'(bus.busy), 1);
    endtask

    // Drives out_ready (stalling beat index stall_beat for stall_len cycles) until done.
    task automatic wait_done(input string tag, input int stall_beat, input int stall_len, output int done_off);
        int acc;
        int st;
        int ha;
        int hb;
        int hp;
        acc = 0;
        st = 0;
        ha = 0;
        hb = 0;
        hp = 0;
        done_off = -1;
        for (int k = 1; k <= 64; k++) begin
            if (bus.done) begin
                done_off = k;
                break;
            end
            if (bus.out_valid && acc == stall_beat && st < stall_len) begin
                if (st == 0) begin
                    ha = int'(bus.out_digit_a);
                    hb = int'(bus.out_digit_b);
                    hp = int'(bus.out_pos);
                end else begin
                    chk($sformatf("%s_hold_a", tag), int'(bus.out_digit_a), ha);
                    chk($sformatf("%s_hold_b", tag), int'(bus.out_digit_b), hb);
                    chk($sformatf("%s_hold_pos", tag), int'(bus.out_pos), hp);
                    chk($sformatf("%s_hold_valid", tag), int'(bus.out_valid), 1);
                end
                bus.out_ready = 1'b0;
                st++;
            end else begin
                bus.out_ready = 1'b1;
                if (bus.out_valid) acc++;
            end
            tick();
        end
        bus.out_ready = 1'b1;
        if (done_off < 0) begin
            chk($sformatf("%s_done_timeout", tag), 0, 1);
        end else begin
            chk($sformatf("%s_in_ready_at_done", tag), int'(bus.in_ready), 0);
            chk($sformatf("%s_out_valid_at_done", tag), int'(bus.out_valid), 0);
            tick();
            chk($sformatf("%s_done_one_cycle", tag), int'(bus.done), 0);
            chk($sformatf("%s_in_ready_after_done", tag), int'(bus.in_ready), 1);
            chk($sformatf("%s_busy_after_done", tag), int'(bus.busy), 0);
        end
    endtask

    initial begin
        int cap;
        int off;
        beat_t g;

        bus.clear     = 1'b0;
        bus.mode      = 1'b0;
        bus.skip_zero = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;

        repeat (3) tick();
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_out_first", int'(bus.out_first), 0);
        chk("rst_out_pos", int'(bus.out_pos), 0);
        chk("rst_out_digit_a", int'(bus.out_digit_a), 0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", int'(bus.in_ready), 1);

        // Cross product, no backpressure.
        start_op(16'h1234, 16'h5678, 1'b0, 1'b0, cap);
        wait_done("t1", -1, 0, off);
        chk("t1_done_off", off, 17);
        chk("t1_done_log", (done_cyc.size() == 1) ? done_cyc[0] - cap : -1, 17);
        build_exp(16'h1234, 16'h5678, 1'b0, 1'b0);
        compare_beats("t1");
        g = get_beat(0);
        chk("t1_hand0", g.a * 256 + g.b * 16 + g.pos, 16'h480);
        chk("t1_first_cyc", g.cyc - cap, 1);
        g = get_beat(1);
        chk("t1_hand1", g.a * 256 + g.b * 16 + g.pos, 16'h381);
        g = get_beat(4);
        chk("t1_hand4", g.a * 256 + g.b * 16 + g.pos, 16'h471);
        g = get_beat(15);
        chk("t1_hand15", g.a * 256 + g.b * 16 + g.pos, 16'h156);
        chk("t1_last_cyc", g.cyc - cap, 16);

        // Diagonal.
        start_op(16'h1234, 16'h5678, 1'b1, 1'b0, cap);
        wait_done("t2", -1, 0, off);
        chk("t2_done_off", off, 5);
        build_exp(16'h1234, 16'h5678, 1'b1, 1'b0);
        compare_beats("t2");
        g = get_beat(1);
        chk("t2_hand1", g.a * 256 + g.b * 16 + g.pos, 16'h372);
        g = get_beat(3);
        chk("t2_hand3", g.a * 256 + g.b * 16 + g.pos, 16'h156);

        // Zero skipping: a single surviving pair, then none at all.
        start_op(16'h0100, 16'h0030, 1'b0, 1'b1, cap);
        wait_done("t3a", -1, 0, off);
        chk("t3a_done_off", off, 17);
        chk("t3a_count", beats.size(), 1);
        g = get_beat(0);
        chk("t3a_hand0", g.a * 256 + g.b * 16 + g.pos, 16'h133);
        chk("t3a_first", g.first, 1);
        chk("t3a_beat_cyc", g.cyc - cap, 7);

        start_op(16'h0000, 16'h0030, 1'b0, 1'b1, cap);
        wait_done("t3b", -1, 0, off);
        chk("t3b_done_off", off, 17);
        chk("t3b_count", beats.size(), 0);

        // Backpressure on beat 2 for three cycles.
        start_op(16'h1234, 16'h5678, 1'b0, 1'b0, cap);
        wait_done("t4", 1, 3, off);
        chk("t4_done_off", off, 20);
        build_exp(16'h1234, 16'h5678, 1'b0, 1'b0);
        compare_beats("t4");

        // Clear after five accepted beats.
        start_op(16'h1234, 16'h5678, 1'b0, 1'b0, cap);
        for (int k = 0; k < 40 && beats.size() < 5; k++) tick();
        chk("t5_five_beats", beats.size(), 5);
        bus.clear     = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.clear     = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("t5_out_valid_after_clear", int'(bus.out_valid), 0);
        chk("t5_in_ready_after_clear", int'(bus.in_ready), 1);
        chk("t5_busy_after_clear", int'(bus.busy), 0);
        repeat (20) tick();
        chk("t5_no_done", done_cyc.size(), 0);
        chk("t5_no_extra_beats", beats.size(), 5);

        // Clear in IDLE blocks a simultaneous capture.
        bus.in_a     = 16'h1234;
        bus.in_b     = 16'h5678;
        bus.in_valid = 1'b1;
        bus.clear    = 1'b1;
        #1;
        chk("t5_in_ready_under_clear", int'(bus.in_ready), 0);
        tick();
        bus.in_valid = 1'b0;
        bus.clear    = 1'b0;
        #1;
        chk("t5_no_capture_under_clear", int'(bus.busy), 0);

        start_op(16'h1111, 16'h2222, 1'b0, 1'b0, cap);
        wait_done("t5b", -1, 0, off);
        chk("t5b_done_off", off, 17);
        build_exp(16'h1111, 16'h2222, 1'b0, 1'b0);
        compare_beats("t5b");

        // Asynchronous reset in the middle of an operation.
        start_op(16'h1234, 16'h5678, 1'b0, 1'b0, cap);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("t6_out_valid", int'(bus.out_valid), 0);
        chk("t6_busy", int'(bus.busy), 0);
        chk("t6_out_first", int'(bus.out_first), 0);
        chk("t6_out_digit_a", int'(bus.out_digit_a), 0);
        chk("t6_out_digit_b", int'(bus.out_digit_b), 0);
        chk("t6_out_pos", int'(bus.out_pos), 0);
        chk("t6_done", int'(bus.done), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_in_ready_after_release", int'(bus.in_ready), 1);
        start_op(16'h2143, 16'h0001, 1'b1, 1'b1, cap);
        wait_done("t6b", -1, 0, off);
        chk("t6b_done_off", off, 5);
        build_exp(16'h2143, 16'h0001, 1'b1, 1'b1);
        compare_beats("t6b");
        g = get_beat(0);
        chk("t6b_hand0", g.a * 256 + g.b * 16 + g.pos, 16'h310);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/digit_pair_sequencer.md
Name: digit_pair_sequencer

Overview:
Parametrised operand staging and digit-selection block for the hex multiplier datapath. It accepts two DIGITS-wide operands through a valid/ready handshake, then streams digit pairs to the digit multiplier under an output valid/ready handshake. Each pair carries its weight position i+j. It supports a full cross-product mode, a diagonal mode, and optional skipping of zero-digit pairs, and signals completion with a one-cycle done pulse.

Parameters:
DIGITS, 4, number of digits per operand (>=2)
DIGIT_W, 4, bits per digit
IDX_W, $clog2(DIGITS), derived: digit index width
POS_W, $clog2(2*DIGITS-1), derived: position output width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous abort; returns block to IDLE
mode  input  1  0 = cross product (DIGITS*DIGITS pairs); 1 = diagonal (DIGITS pairs, i==j)
skip_zero  input  1  1 = suppress pairs where either digit is 0
in_valid  input  1  operand pair offered
in_ready  output  1  block can accept operands
in_a  input  DIGITS*DIGIT_W  operand A; digit k = in_a[k*DIGIT_W +: DIGIT_W], digit 0 = LS
in_b  input  DIGITS*DIGIT_W  operand B, same layout
out_valid  output  1  digit pair valid
out_ready  input  1  consumer accepts pair
out_digit_a  output  DIGIT_W  A digit i
out_digit_b  output  DIGIT_W  B digit j
out_pos  output  POS_W  i+j
out_first  output  1  first emitted pair of current operation
done  output  1  one-cycle pulse at end of operation
busy  output  1  high in RUN and DONE

Behaviour:
- Reset (rst_n low, async): state IDLE; operand regs, i, j = 0; out_valid, out_*, out_first, done, busy = 0. in_ready = 1 once reset is released.
- States: IDLE, RUN, DONE.
- IDLE: in_ready = 1. On in_valid&&in_ready, latch in_a, in_b, mode and skip_zero (held for the whole operation); i = j = 0; next state RUN.
- RUN: candidate = (a[i], b[j]). skipped = skip_zero && (a[i]==0 || b[j]==0).
- out_valid = !skipped. out_digit_a/out_digit_b/out_pos are driven from the candidate.
- The candidate advances when (out_valid && out_ready) or skipped. One candidate is evaluated per cycle at most.
- Cross order: i is the inner loop, j the outer: (0,0),(1,0)..(DIGITS-1,0),(0,1)... up to (DIGITS-1,DIGITS-1).
- Diagonal order: (0,0),(1,1)..(DIGITS-1,DIGITS-1).
- When the final candidate advances, next state is DONE.
- First beat is valid in the cycle after the capture edge. Zero added latency.
- Backpressure: while out_valid && !out_ready, all out_* hold stable and i, j do not change.
- out_first: high on the first non-skipped candidate of an operation until it is accepted. It is 0 on all later beats.
- DONE: lasts one cycle. done = 1, in_ready = 0, out_valid = 0. Next state is IDLE.
- Minimum operation length is candidates + 1 cycles after capture. in_ready returns 1 in the cycle after done.
- All pairs skipped (e.g. an operand is 0): no beats are emitted, but done still pulses after all candidates are scanned.
- clear: synchronous and overrides all other inputs. Next state is IDLE, out_valid = 0, no done pulse.
- If clear is high in IDLE with in_valid high, clear wins and nothing is captured (in_ready = 0 while clear = 1).
- mode and skip_zero changes during RUN have no effect on the current operation.
- Async reset mid-operation aborts immediately to reset values.
- out_pos max = 2*DIGITS-2 and never wraps.

Test Plan:
1. DIGITS=4, DIGIT_W=4, in_a=0x1234, in_b=0x5678, mode=0, skip_zero=0, out_ready=1 -> 16 consecutive beats: (4,8,0),(3,8,1),(2,8,2),(1,8,3),(4,7,1)...(1,5,6). out_first only on beat 1. done 1 cycle after the last beat. in_ready high 1 cycle after done.
2. Same operands, mode=1 -> 4 beats: (4,8,0),(3,7,2),(2,6,4),(1,5,6). done follows the last beat.
3. skip_zero=1, in_a=0x0100, in_b=0x0030, mode=0 -> a single beat (1,3,pos 3) with out_first=1. done 17 cycles after the capture edge. With in_a=0x0000 -> zero beats, done at the same cycle.
4. Backpressure: hold out_ready=0 for 3 cycles on beat 2 of scenario 1 -> (3,8,1) held stable. The full 16-beat sequence arrives with no loss or duplicate.
5. Assert clear after 5 accepted beats -> out_valid=0 and in_ready=1 next cycle, no done. A new capture of 0x1111/0x2222 then produces 16 beats of (1,2).
6. Drop rst_n mid-RUN -> all outputs 0 immediately (async). After release, in_ready=1 and a fresh operation completes normally.
